// File: rtl/lsu_mem_responder_pkg.sv
// Shared types for the LSU/TMA scratchpad responder.
// The response payload travels through the read pipeline and response queue.
package lsu_mem_responder_pkg;

    localparam int LSU_NUM_LANES  = 4;
    localparam int LSU_WORD_SIZE  = 4;
    localparam int LSU_ADDR_WIDTH = 32;
    localparam int LSU_MEM_WORDS  = 1024;
    localparam int LSU_TAG_WIDTH  = 8;
    localparam int LSU_LATENCY    = 2;
    localparam int LSU_RSP_DEPTH  = 4;

    localparam int LSU_WORD_W = LSU_WORD_SIZE * 8;
    localparam int MEM_IDX_W  = $clog2(LSU_MEM_WORDS);

    typedef struct packed {
        logic [LSU_NUM_LANES-1:0]            mask;
        logic [LSU_NUM_LANES*LSU_WORD_W-1:0] data;
        logic [LSU_TAG_WIDTH-1:0]            tag;
    } lsu_rsp_t;

endpackage

// File: rtl/lsu_mem_responder_fifo.sv
// Show-ahead response queue: the head entry is visible whenever valid_o is high.
// Synchronous active-low reset; pushing into a full queue is flagged as an error.
module lsu_mem_responder_fifo
    import lsu_mem_responder_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] buf_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full, empty;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;
    assign valid_o = !empty;
    assign data_o  = buf_q[rptr_q];

    // Next pointer and occupancy values.
    always_comb begin
        wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = do_pop ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            buf_q[wptr_q] <= data_i;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset) !(push_i && full)
    ) else $error("response queue overflow");

endmodule

// File: rtl/lsu_mem_responder.sv
// Multi-ported scratchpad slave for lane-vector LSU/TMA requests.
// Byte-enabled stores, in-order tagged load responses after a fixed latency.
module lsu_mem_responder
    import lsu_mem_responder_pkg::*;
#(
    parameter int NUM_LANES  = LSU_NUM_LANES,
    parameter int WORD_SIZE  = LSU_WORD_SIZE,
    parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
    parameter int MEM_WORDS  = LSU_MEM_WORDS,
    parameter int TAG_WIDTH  = LSU_TAG_WIDTH,
    parameter int LATENCY    = LSU_LATENCY,
    parameter int RSP_DEPTH  = LSU_RSP_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    input  logic                              req_rw,
    input  logic [NUM_LANES-1:0]              req_mask,
    input  logic [NUM_LANES*WORD_SIZE-1:0]    req_byteen,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_LANES*WORD_SIZE*8-1:0]  req_data,
    input  logic [TAG_WIDTH-1:0]              req_tag,
    output logic                              req_ready,
    output logic                              rsp_valid,
    output logic [NUM_LANES-1:0]              rsp_mask,
    output logic [NUM_LANES*WORD_SIZE*8-1:0]  rsp_data,
    output logic [TAG_WIDTH-1:0]              rsp_tag,
    input  logic                              rsp_ready
);

    localparam int WORD_W = WORD_SIZE * 8;
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    // The queue register supplies the last cycle of latency.
    localparam int PIPE   = LATENCY - 1;

    logic [WORD_W-1:0] mem_q [MEM_WORDS];
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic              ld_fire, st_fire, rsp_fire;
    lsu_rsp_t          rd_pl, enq_pl, deq_pl;
    logic              enq_v, deq_v;
    logic              unused_addr;

    // Upper address bits are deliberately ignored so addresses wrap.
    assign unused_addr = ^req_addr;

    assign req_ready = reset && (outst_q < CNT_W'(RSP_DEPTH));
    assign st_fire   = req_valid && req_ready && req_rw;
    assign ld_fire   = req_valid && req_ready && !req_rw;

    // Multi-port array read; inactive lanes return zero.
    always_comb begin
        rd_pl      = '0;
        rd_pl.mask = req_mask;
        rd_pl.tag  = req_tag;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (req_mask[l]) begin
                rd_pl.data[l*WORD_W +: WORD_W] =
                    mem_q[req_addr[l*ADDR_WIDTH +: IDX_W]];
            end
        end
    end

    // Byte-enabled store; later lanes overwrite earlier ones on conflict.
    always_ff @(posedge clk) begin
        if (st_fire) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int b = 0; b < WORD_SIZE; b++) begin
                    if (req_mask[l] && req_byteen[l*WORD_SIZE+b]) begin
                        mem_q[req_addr[l*ADDR_WIDTH +: IDX_W]][b*8 +: 8]
                            <= req_data[(l*WORD_SIZE+b)*8 +: 8];
                    end
                end
            end
        end
    end

    if (PIPE == 0) begin : g_no_pipe
        assign enq_v  = ld_fire;
        assign enq_pl = rd_pl;
    end else begin : g_pipe
        logic [PIPE-1:0] pv_q;
        lsu_rsp_t        pd_q [PIPE];

        // Valid bits of the read pipeline, cleared on reset.
        always_ff @(posedge clk) begin
            if (!reset) begin
                pv_q <= '0;
            end else begin
                pv_q[0] <= ld_fire;
                for (int i = 1; i < PIPE; i++) begin
                    pv_q[i] <= pv_q[i-1];
                end
            end
        end

        // Payload shift register; qualified by the valid bits.
        always_ff @(posedge clk) begin
            pd_q[0] <= rd_pl;
            for (int i = 1; i < PIPE; i++) begin
                pd_q[i] <= pd_q[i-1];
            end
        end

        assign enq_v  = pv_q[PIPE-1];
        assign enq_pl = pd_q[PIPE-1];
    end

    lsu_mem_responder_fifo #(
        .DATA_W ($bits(lsu_rsp_t)),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_q (
        .clk     (clk),
        .reset   (reset),
        .push_i  (enq_v),
        .data_i  (enq_pl),
        .pop_i   (rsp_fire),
        .valid_o (deq_v),
        .data_o  (deq_pl)
    );

    assign rsp_valid = reset && deq_v;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign rsp_mask  = rsp_valid ? deq_pl.mask : '0;
    assign rsp_data  = rsp_valid ? deq_pl.data : '0;
    assign rsp_tag   = rsp_valid ? deq_pl.tag : '0;

    // Outstanding-load credit: +1 per accepted load, -1 per consumed response.
    always_comb begin
        outst_d = outst_q;
        if (ld_fire && !rsp_fire) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!ld_fire && rsp_fire) begin
            outst_d = outst_q - CNT_W'(1);
        end
    end

    // Credit counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            outst_q <= '0;
        end else begin
            outst_q <= outst_d;
        end
    end

    a_outst_bound: assert property (
        @(posedge clk) disable iff (!reset) outst_q <= CNT_W'(RSP_DEPTH)
    ) else $error("outstanding counter out of range");

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Randomized bench for lsu_mem_responder against a queue-based memory model.
// Each cycle checks ready, response validity and response contents.
module tb_lsu_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int WORDS = 1024;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_rw = 1'b0;
    logic [3:0]   req_mask = '0;
    logic [15:0]  req_byteen = '0;
    logic [127:0] req_addr = '0;
    logic [127:0] req_data = '0;
    logic [7:0]   req_tag = '0;
    logic         req_ready;
    logic         rsp_valid;
    logic [3:0]   rsp_mask;
    logic [127:0] rsp_data;
    logic [7:0]   rsp_tag;
    logic         rsp_ready = 1'b0;

    lsu_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_mask   (req_mask),
        .req_byteen (req_byteen),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_mask   (rsp_mask),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           arrive;
        logic [7:0]   tag;
        logic [3:0]   mask;
        logic [127:0] data;
    } exp_t;

    exp_t         mq[$];
    logic [31:0]  mm [WORDS];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_acc = 0;
    int           n_rsp = 0;
    logic [127:0] last_data;
    logic [3:0]   last_mask;
    logic [7:0]   last_tag;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a % 32'(WORDS));
    endfunction

    function automatic logic [127:0] l0(input logic [31:0] x);
        return {96'd0, x};
    endfunction

    // One cycle: drive at negedge, check, update model, advance.
    task automatic step(input logic v, input logic rw, input logic [3:0] m,
                        input logic [15:0] be, input logic [127:0] a,
                        input logic [127:0] d, input logic [7:0] t,
                        input logic rr);
        bit   er, ev;
        exp_t e;
        req_valid  = v;
        req_rw     = rw;
        req_mask   = m;
        req_byteen = be;
        req_addr   = a;
        req_data   = d;
        req_tag    = t;
        rsp_ready  = rr;
        #1;
        er = (mq.size() < DEPTH);
        ev = (mq.size() > 0) && (mq[0].arrive <= cyc);
        chk("req_ready", 128'(req_ready), 128'(er));
        chk("rsp_valid", 128'(rsp_valid), 128'(ev));
        if (ev) begin
            chk("rsp_mask", 128'(rsp_mask), 128'(mq[0].mask));
            chk("rsp_data", rsp_data, mq[0].data);
            chk("rsp_tag", 128'(rsp_tag), 128'(mq[0].tag));
        end
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            last_data = rsp_data;
            last_mask = rsp_mask;
            last_tag  = rsp_tag;
        end
        if (v && req_ready) n_acc++;
        if (ev && rr) void'(mq.pop_front());
        if (v && er) begin
            if (rw) begin
                for (int l = 0; l < 4; l++)
                    for (int b = 0; b < 4; b++)
                        if (m[l] && be[l*4+b])
                            mm[widx(a[l*32 +: 32])][b*8 +: 8] =
                                d[(l*4+b)*8 +: 8];
            end else begin
                e.arrive = cyc + LAT;
                e.tag    = t;
                e.mask   = m;
                e.data   = '0;
                for (int l = 0; l < 4; l++)
                    if (m[l]) e.data[l*32 +: 32] = mm[widx(a[l*32 +: 32])];
                mq.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 1'b0, 4'h0, 16'h0, '0, '0, 8'h0, rr);
    endtask

    task automatic drain();
        int k = 0;
        while (mq.size() > 0 && k < 40) begin
            idle(1'b1);
            k++;
        end
        chk("drain", 128'(mq.size()), 128'd0);
    endtask

    // Hold reset low for n cycles with a request pending.
    task automatic do_reset(input int n);
        reset     = 1'b0;
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_mask  = 4'hF;
        rsp_ready = 1'b1;
        repeat (n) begin
            #1;
            chk("rst_req_ready", 128'(req_ready), 128'd0);
            chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
            chk("rst_rsp_data", rsp_data, 128'd0);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        mq.delete();
        reset = 1'b1;
    endtask

    initial begin
        logic [127:0] a;
        logic [127:0] d;
        @(negedge clk);
        do_reset(3);
        idle(1'b1);

        for (int i = 0; i < 8; i++) begin
            a = '0;
            d = '0;
            for (int l = 0; l < 4; l++) begin
                a[l*32 +: 32] = 32'(4*i + l);
                d[l*32 +: 32] = $urandom;
            end
            step(1'b1, 1'b1, 4'hF, 16'hFFFF, a, d, 8'h0, 1'b1);
        end

        step(1'b1, 1'b1, 4'h1, 16'h000F, l0(5), l0(32'hDEADBEEF), 8'h0, 1'b1);
        step(1'b1, 1'b0, 4'h1, 16'h0, l0(5), '0, 8'h11, 1'b1);
        drain();
        chk("st_ld_data", 128'(last_data[31:0]), 128'(32'hDEADBEEF));
        chk("st_ld_tag", 128'(last_tag), 128'h11);

        step(1'b1, 1'b1, 4'h1, 16'h000F, l0(6), l0(32'h11223344), 8'h0, 1'b1);
        step(1'b1, 1'b1, 4'h1, 16'h0003, l0(6), l0(32'hAABBCCDD), 8'h0, 1'b1);
        step(1'b1, 1'b0, 4'h1, 16'h0, l0(6), '0, 8'h22, 1'b1);
        drain();
        chk("byteen", 128'(last_data[31:0]), 128'(32'h1122CCDD));

        a = {32'd7, 32'd0, 32'd7, 32'd0};
        d = {32'h3, 32'h0, 32'h1, 32'h0};
        step(1'b1, 1'b1, 4'b1010, 16'hFFFF, a, d, 8'h0, 1'b1);
        step(1'b1, 1'b0, 4'h1, 16'h0, l0(7), '0, 8'h23, 1'b1);
        drain();
        chk("lane_conflict", 128'(last_data[31:0]), 128'h3);

        n_acc = 0;
        n_rsp = 0;
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b0, 4'h1, 16'h0, l0(32'(i)), '0, 8'(8'h40 + i), 1'b0);
        #1;
        chk("bp_accepted", 128'(n_acc), 128'd4);
        chk("bp_ready_low", 128'(req_ready), 128'd0);
        drain();
        chk("bp_responses", 128'(n_rsp), 128'd4);
        chk("bp_last_tag", 128'(last_tag), 128'h43);

        step(1'b1, 1'b1, 4'h1, 16'h000F, l0(3), l0(32'hCAFEF00D), 8'h0, 1'b1);
        a = {4{32'(WORDS + 3)}};
        step(1'b1, 1'b0, 4'b0101, 16'h0, a, '0, 8'h55, 1'b1);
        drain();
        chk("wrap_mask", 128'(last_mask), 128'h5);
        chk("wrap_data", last_data, {32'd0, 32'hCAFEF00D, 32'd0, 32'hCAFEF00D});

        n_acc = 0;
        n_rsp = 0;
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, 4'hF, 16'h0, {4{32'(i)}}, '0, 8'(i), 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("stream_acc", 128'(n_acc), 128'd16);
        chk("stream_rsp", 128'(n_rsp), 128'd16);

        step(1'b1, 1'b0, 4'hF, 16'h0, '0, '0, 8'hA0, 1'b0);
        step(1'b1, 1'b0, 4'hF, 16'h0, '0, '0, 8'hA1, 1'b0);
        do_reset(2);
        n_rsp = 0;
        repeat (4) idle(1'b1);
        chk("rst_no_rsp", 128'(n_rsp), 128'd0);
        n_acc = 0;
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 4'h1, 16'h0, '0, '0, 8'(8'hB0 + i), 1'b0);
        chk("rst_outst_zero", 128'(n_acc), 128'd4);
        drain();

        for (int i = 0; i < 400; i++) begin
            a = '0;
            for (int l = 0; l < 4; l++)
                a[l*32 +: 32] = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31));
            d = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom % 4) != 0, $urandom % 2, 4'($urandom), 16'($urandom),
                 a, d, 8'($urandom), ($urandom % 4) != 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
